axis_uart_tx_fifo: RTL and testbench
====================================

Name: axis_uart_tx_fifo

Overview:
Parametrised AXI-Stream-to-UART transmitter with an internal TX FIFO. It also adds runtime-selectable character length, CTS hardware flow control and break generation. It sits between an AXIS master and the UART pin. Configuration comes from APB register outputs and is sampled per frame.

Parameters:
DATA_W, 8, maximum character length in bits (legal 5..9); width of s_axis_tdata_i
FIFO_DEPTH, 16, TX FIFO entries (power of 2, >=2)
DIV_W, 16, width of the baud divisor

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata_i  in  DATA_W  character to send, LSB first
s_axis_tvalid_i  in  1  AXIS valid
s_axis_tready_o  out  1  AXIS ready = FIFO not full
cfg_div_i  in  DIV_W  bit period minus 1, in clk cycles
cfg_data_bits_i  in  4  character length
cfg_parity_i  in  3  0 none, 1 force 0, 2 force 1, 3 odd, 4 even, others none
cfg_stop2_i  in  1  0 = 1 stop bit, 1 = 2 stop bits
cfg_break_i  in  1  request break (line held low)
cts_n_i  in  1  clear-to-send, active low, asynchronous
uart_tx_o  out  1  serial line, idle high
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
busy_o  out  1  FSM not IDLE or FIFO non-empty
tx_done_o  out  1  one-cycle pulse at end of each frame's last stop bit

Behaviour:
- Reset values:
  - uart_tx_o = 1, s_axis_tready_o = 1, fifo_level_o = 0, busy_o = 0, tx_done_o = 0.
  - FIFO is emptied and the FSM goes to IDLE.
  - Asserting reset mid-frame aborts the frame immediately; the line goes high asynchronously.
- FIFO:
  - Push on tvalid && tready.
  - s_axis_tready_o = (level != FIFO_DEPTH), decoded from registered level.
  - When full, the next push is accepted only in the cycle after the pop cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; order is strictly FIFO.
- cts_n_i:
  - Passes through a 2-flop synchroniser.
  - Checked only at frame start; deassertion mid-frame lets the current frame finish.
- Config sampling:
  - cfg_div, data_bits, parity and stop2 are latched in the cycle a word is popped.
  - Changes mid-frame take effect on the next frame.
  - data_bits < 5 is treated as 5; data_bits > DATA_W is treated as DATA_W.
- Bit timing:
  - Every line bit lasts exactly cfg_div+1 clk cycles. cfg_div=0 gives 1 clk per bit.
  - The divisor counter restarts at every frame start.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK, GUARD.
  - IDLE -> BREAK when cfg_break_i=1. Break has priority over FIFO data.
  - IDLE -> START when the FIFO is non-empty, synced CTS is low and break is 0. Pop in this transition cycle.
  - START: drive 0 for one bit period, then -> DATA.
  - DATA: send data_bits bits, LSB first; bits above data_bits are ignored. Then -> PARITY if parity != none, else -> STOP.
  - PARITY: bit value is
    - force 0 -> 0; force 1 -> 1;
    - odd -> ~^data; even -> ^data, each over the data_bits bits only.
  - STOP: drive 1 for 1 or 2 bit periods. Assert tx_done_o in the last cycle, then -> IDLE.
  - Back-to-back frames: the next start bit follows the stop bit with at most 1 clk of extra idle.
  - BREAK: line 0 while cfg_break_i=1. Break is using the divisor latched at entry. On release -> GUARD.
  - GUARD: line 1 for one bit period, then -> IDLE.
  - cfg_break_i asserted mid-frame is ignored until IDLE.
- Latency: with FSM IDLE, synced CTS low and the FIFO empty, the start bit appears on uart_tx_o 2 clk edges after the accepting handshake edge.
- uart_tx_o is a registered output and is glitch-free.

Test Plan:
- Framing: div=3, 8 bits, parity none, 1 stop; push 0xA5 -> line 0,1,0,1,0,0,1,0,1,1; each bit 4 clk; frame 40 clk; tx_done_o pulses once.
- Parity and stop bits: 7 bits, even parity, 2 stop; push 0x7F -> 0, seven 1s, parity 1, 1, 1 (11 bits). The same with odd parity -> parity 0.
- Flow control: FIFO_DEPTH=4, cts_n=1; push 5 words 0x01..0x05 -> 4 accepted, tready=0, level=4, line idle. Set cts_n=0 -> frames 0x01..0x04 in order, then 0x05 accepted.
- CTS and config mid-frame: cts_n 0->1 mid-frame -> frame completes, next waits. Change cfg_div mid-frame -> current frame timing unchanged.
- Break: div=1; break high for 20 clk while IDLE -> line low 20 clk, then high 2 clk (GUARD), then pending FIFO data starts.
- Reset mid-frame: assert rst_n=0 during a DATA bit -> uart_tx_o=1 immediately, level=0. After release, no residual frame is sent.

Source files
------------

// File: rtl/axis_uart_tx_fifo.sv
// Purpose : AXI-Stream to UART transmitter with TX FIFO, runtime char length/parity/stop, CTS gating and break.
// Latency : start bit on uart_tx_o 2 clk edges after the accepting handshake (FSM idle, FIFO empty, CTS low).
// Backpr. : s_axis_tready_o = FIFO not full (registered level); a full FIFO reopens the cycle after a pop.
// Ports   : clk/rst_n (async active-low); s_axis_* AXIS slave; cfg_* per-frame config (sampled at pop);
//           cts_n_i async clear-to-send; uart_tx_o serial line; fifo_level_o, busy_o, tx_done_o status.
module axis_uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             s_axis_tdata_i,
   input  logic                          s_axis_tvalid_i,
   output logic                          s_axis_tready_o,
   input  logic [DIV_W-1:0]              cfg_div_i,
   input  logic [3:0]                    cfg_data_bits_i,
   input  logic [2:0]                    cfg_parity_i,
   input  logic                          cfg_stop2_i,
   input  logic                          cfg_break_i,
   input  logic                          cts_n_i,
   output logic                          uart_tx_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic                          tx_done_o
);
   localparam int              AW       = $clog2(FIFO_DEPTH);
   localparam int              LW       = AW + 1;
   localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [3:0]      MAX_BITS = 4'(DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_GUARD} state_t;

   // ---------------- FIFO ----------------
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [LW-1:0]     r_level;
   logic              w_push, w_pop;
   logic [DATA_W-1:0] w_head;

   assign s_axis_tready_o = (r_level != FULL_LVL);
   assign w_push          = s_axis_tvalid_i && s_axis_tready_o;
   assign w_head          = r_mem[r_rptr];
   assign fifo_level_o    = r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= s_axis_tdata_i;
   end

   // ---------------- CTS synchroniser (resets to "not clear") ----------------
   logic r_cts_s1, r_cts_s2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cts_s1 <= 1'b1;
         r_cts_s2 <= 1'b1;
      end else begin
         r_cts_s1 <= cts_n_i;
         r_cts_s2 <= r_cts_s1;
      end
   end

   // ---------------- Config decode (applied to the word at the FIFO head) ----------------
   logic [3:0]        w_nbits;
   logic [DATA_W-1:0] w_mask;
   logic              w_xor, w_par_en, w_par_val;

   always_comb begin
      w_nbits = cfg_data_bits_i;
      if (cfg_data_bits_i < 4'd5)         w_nbits = 4'd5;
      else if (cfg_data_bits_i > MAX_BITS) w_nbits = MAX_BITS;
      for (int i = 0; i < DATA_W; i++) w_mask[i] = (i < int'(w_nbits));
   end

   assign w_xor = ^(w_head & w_mask);

   always_comb begin
      w_par_en  = 1'b1;
      w_par_val = 1'b0;
      case (cfg_parity_i)
         3'd1:    w_par_val = 1'b0;
         3'd2:    w_par_val = 1'b1;
         3'd3:    w_par_val = ~w_xor;
         3'd4:    w_par_val = w_xor;
         default: w_par_en  = 1'b0;
      endcase
   end

   // ---------------- Frame state ----------------
   state_t            r_state, w_state_nxt;
   logic [DIV_W-1:0]  r_div, r_cnt;
   logic [3:0]        r_nbits, r_bit;
   logic              r_par_en, r_par_val, r_stop2;
   logic [DATA_W-1:0] r_shift;
   logic              w_tick, w_last_stop, w_go_start, w_brk_entry;
   state_t            w_resume;
   logic              w_tx_nxt, w_done_nxt, r_tx, r_done;

   assign w_tick      = (r_cnt == r_div);
   assign w_last_stop = r_stop2 ? (r_bit == 4'd1) : 1'b1;
   assign w_go_start  = (r_level != '0) && !r_cts_s2 && !cfg_break_i;
   // Where a finished frame/guard goes next: break first, then data, else idle.
   // Going straight to START avoids an idle cycle between back-to-back frames.
   assign w_resume    = cfg_break_i ? S_BREAK : (w_go_start ? S_START : S_IDLE);
   assign w_pop       = (w_state_nxt == S_START) && (r_state != S_START);
   assign w_brk_entry = (w_state_nxt == S_BREAK) && (r_state != S_BREAK);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   w_state_nxt = w_resume;
         S_START:  if (w_tick) w_state_nxt = S_DATA;
         S_DATA:   if (w_tick && (r_bit == r_nbits - 4'd1))
                      w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_tick) w_state_nxt = S_STOP;
         S_STOP:   if (w_tick && w_last_stop) w_state_nxt = w_resume;
         S_BREAK:  if (!cfg_break_i) w_state_nxt = S_GUARD;
         S_GUARD:  if (w_tick) w_state_nxt = w_resume;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic (registered below so the line is glitch-free)
   always_comb begin
      w_tx_nxt   = 1'b1;
      w_done_nxt = 1'b0;
      case (r_state)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = r_shift[0];
         S_PARITY: w_tx_nxt = r_par_val;
         S_STOP:   w_done_nxt = w_tick && w_last_stop;
         S_BREAK:  w_tx_nxt = 1'b0;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx   <= 1'b1;
         r_done <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign uart_tx_o = r_tx;
   assign tx_done_o = r_done;
   assign busy_o    = (r_state != S_IDLE) || (r_level != '0);

   // Bit timer, bit index and per-frame config snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_bit     <= '0;
         r_div     <= '0;
         r_nbits   <= 4'd5;
         r_par_en  <= 1'b0;
         r_par_val <= 1'b0;
         r_stop2   <= 1'b0;
         r_shift   <= '0;
      end else begin
         // Timer restarts on every state change, so each line bit is r_div+1 cycles.
         if ((w_state_nxt != r_state) || w_tick) r_cnt <= '0;
         else                                    r_cnt <= r_cnt + 1'b1;

         if (w_state_nxt != r_state)                               r_bit <= '0;
         else if (w_tick && (r_state == S_DATA || r_state == S_STOP)) r_bit <= r_bit + 1'b1;

         if (w_pop) begin
            r_div     <= cfg_div_i;
            r_nbits   <= w_nbits;
            r_par_en  <= w_par_en;
            r_par_val <= w_par_val;
            r_stop2   <= cfg_stop2_i;
            r_shift   <= w_head;
         end else begin
            if (w_brk_entry) r_div <= cfg_div_i;
            if (r_state == S_DATA && w_tick) r_shift <= r_shift >> 1;
         end
      end
   end
endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
module tb_axis_uart_tx_fifo;
   localparam int DW = 8;
   localparam int FD = 4;
   localparam int VW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_axis_tdata_i = '0;
   logic          s_axis_tvalid_i = 1'b0;
   logic          s_axis_tready_o;
   logic [VW-1:0] cfg_div_i = '0;
   logic [3:0]    cfg_data_bits_i = 4'd8;
   logic [2:0]    cfg_parity_i = 3'd0;
   logic          cfg_stop2_i = 1'b0;
   logic          cfg_break_i = 1'b0;
   logic          cts_n_i = 1'b0;
   logic          uart_tx_o;
   logic [2:0]    fifo_level_o;
   logic          busy_o;
   logic          tx_done_o;

   int n_cmp = 0;
   int n_err = 0;

   axis_uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(FD), .DIV_W(VW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tready_o(s_axis_tready_o),
      .cfg_div_i(cfg_div_i), .cfg_data_bits_i(cfg_data_bits_i), .cfg_parity_i(cfg_parity_i),
      .cfg_stop2_i(cfg_stop2_i), .cfg_break_i(cfg_break_i), .cts_n_i(cts_n_i),
      .uart_tx_o(uart_tx_o), .fifo_level_o(fifo_level_o), .busy_o(busy_o), .tx_done_o(tx_done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_cfg(input int div, input int nb, input int par, input bit stop2);
      cfg_div_i       = VW'(div);
      cfg_data_bits_i = 4'(nb);
      cfg_parity_i    = 3'(par);
      cfg_stop2_i     = stop2;
   endtask

   task automatic push(input logic [7:0] d);
      chk("push_ready", s_axis_tready_o, 1);
      s_axis_tdata_i  = d;
      s_axis_tvalid_i = 1'b1;
      tick();
      s_axis_tvalid_i = 1'b0;
   endtask

   task automatic wait_low(input int budget, output int cyc);
      cyc = 0;
      while (uart_tx_o !== 1'b0 && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_len(input logic lvl, input int budget, output int n);
      n = 0;
      while (uart_tx_o === lvl && n < budget) begin
         tick();
         n++;
      end
   endtask

   // Samples every cycle of an nb-bit frame starting at the first start-bit cycle.
   task automatic check_frame(input string tag, input int nb, input int d,
                              input logic [15:0] exp, input int budget, output int gap);
      logic [15:0] bits;
      logic        stable;
      int          done_cnt, done_at;
      wait_low(budget, gap);
      chk({tag, "_start"}, uart_tx_o, 0);
      bits = '0; stable = 1'b1; done_cnt = 0; done_at = -1;
      for (int i = 0; i < nb; i++) begin
         for (int c = 0; c < d; c++) begin
            if (c == 0) bits[i] = uart_tx_o;
            else if (uart_tx_o !== bits[i]) stable = 1'b0;
            if (tx_done_o === 1'b1) begin
               done_cnt++;
               done_at = i * d + c;
            end
            tick();
         end
      end
      chk({tag, "_bits"}, bits, exp);
      chk({tag, "_bit_width"}, stable, 1);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_done_pos"}, done_at, nb * d - 1);
   endtask

   initial begin
      int gap, cyc, acc, acc5, nlow, nhigh;
      logic [15:0] exp;

      // Reset state
      repeat (3) tick();
      chk("rst_line", uart_tx_o, 1);
      chk("rst_ready", s_axis_tready_o, 1);
      chk("rst_level", fifo_level_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", tx_done_o, 0);
      rst_n = 1'b1;
      repeat (4) tick();

      // Basic 8N1 framing, div=3
      set_cfg(3, 8, 0, 0);
      push(8'hA5);
      check_frame("a5", 10, 4, 16'h34A, 50, gap);
      chk("a5_latency", gap, 2);
      chk("a5_idle_line", uart_tx_o, 1);
      chk("a5_idle_busy", busy_o, 0);

      // Parity / 2 stop bits
      set_cfg(1, 7, 4, 1);
      push(8'h7F);
      check_frame("par_even", 11, 2, 16'h7FE, 20, gap);
      set_cfg(1, 7, 3, 1);
      push(8'h7F);
      check_frame("par_odd", 11, 2, 16'h6FE, 20, gap);
      set_cfg(1, 7, 4, 1);
      push(8'h80);
      check_frame("par_ignore_b7", 11, 2, 16'h600, 20, gap);
      set_cfg(1, 5, 2, 0);
      push(8'h00);
      check_frame("par_force1", 8, 2, 16'h0C0, 20, gap);

      // Character length clamping
      set_cfg(0, 3, 0, 0);
      push(8'h0F);
      check_frame("clamp_lo", 7, 1, 16'h05E, 10, gap);
      set_cfg(0, 9, 0, 0);
      push(8'h81);
      check_frame("clamp_hi", 10, 1, 16'h302, 10, gap);

      // Flow control: CTS held off, FIFO fills
      set_cfg(1, 8, 0, 0);
      cts_n_i = 1'b1;
      repeat (3) tick();
      acc = 0;
      for (int i = 1; i <= 5; i++) begin
         s_axis_tdata_i  = 8'(i);
         s_axis_tvalid_i = 1'b1;
         if (s_axis_tready_o) acc++;
         if (i < 5) tick();
      end
      chk("fc_accepted", acc, 4);
      chk("fc_ready_full", s_axis_tready_o, 0);
      chk("fc_level_full", fifo_level_o, 4);
      repeat (10) tick();
      chk("fc_line_idle", uart_tx_o, 1);
      chk("fc_level_hold", fifo_level_o, 4);
      acc5 = 0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if (s_axis_tready_o) begin
                  acc5 = 1;
                  tick();
                  break;
               end
               tick();
            end
            s_axis_tvalid_i = 1'b0;
         end
      join_none
      cts_n_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         exp = 16'h200 | 16'(i << 1);
         check_frame($sformatf("fc_frame%0d", i), 10, 2, exp, 40, gap);
         if (i > 1 && i < 5) chk($sformatf("fc_b2b_gap%0d", i), (gap <= 1), 1);
      end
      chk("fc_word5_accepted", acc5, 1);
      chk("fc_level_empty", fifo_level_o, 0);
      chk("fc_busy_end", busy_o, 0);

      // CTS deasserted and divisor changed mid-frame
      set_cfg(1, 8, 0, 0);
      push(8'h11);
      push(8'h22);
      fork
         check_frame("cts_f1", 10, 2, 16'h222, 20, gap);
         begin
            repeat (6) @(posedge clk);
            #2;
            cts_n_i   = 1'b1;
            cfg_div_i = 16'd5;
         end
      join
      wait_low(30, cyc);
      chk("cts_hold_line", uart_tx_o, 1);
      chk("cts_hold_level", fifo_level_o, 1);
      cts_n_i = 1'b0;
      check_frame("cts_f2_newdiv", 10, 6, 16'h244, 40, gap);

      // Break with pending data
      set_cfg(1, 8, 0, 0);
      cts_n_i = 1'b1;
      repeat (3) tick();
      push(8'h33);
      repeat (2) tick();
      chk("brk_pre_idle", uart_tx_o, 1);
      fork
         begin
            cfg_break_i = 1'b1;
            cts_n_i     = 1'b0;
            repeat (20) tick();
            cfg_break_i = 1'b0;
         end
         begin
            wait_low(10, cyc);
            run_len(1'b0, 100, nlow);
            run_len(1'b1, 20, nhigh);
            chk("brk_low_len", nlow, 20);
            chk("brk_guard_len", nhigh, 2);
            check_frame("brk_data", 10, 2, 16'h266, 10, gap);
         end
      join

      // Reset in the middle of a data bit
      set_cfg(3, 8, 0, 0);
      push(8'h55);
      push(8'h66);
      wait_low(10, cyc);
      repeat (10) tick();
      chk("rst_mid_pre_line", uart_tx_o, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_line", uart_tx_o, 1);
      chk("rst_mid_level", fifo_level_o, 0);
      chk("rst_mid_busy", busy_o, 0);
      chk("rst_mid_ready", s_axis_tready_o, 1);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_low(60, cyc);
      chk("rst_no_residual", uart_tx_o, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
